// File: rtl/glb_dma_pkg.sv
// ============================================================
// glb_dma_pkg : shared FSM encoding and defaults for the GLB read DMA
// Rev 1.0
// ============================================================
`default_nettype none

package glb_dma_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } dma_state_e;

  localparam int unsigned DEFAULT_FIFO_DEPTH = 4;

endpackage

`default_nettype wire

// File: rtl/glb_dma_fifo.sv
// ============================================================
// glb_dma_fifo : synchronous FIFO with occupancy count, zero head when empty
// Rev 1.0
// ============================================================
`default_nettype none

module glb_dma_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push;
  logic             do_pop;

  // A pop in the same cycle frees the slot, so a full FIFO may still accept.
  always_comb begin
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != CW'(DEPTH)) || do_pop);
    wr_ptr_d = wr_ptr_q + (do_push ? AW'(1) : AW'(0));
    rd_ptr_d = rd_ptr_q + (do_pop ? AW'(1) : AW'(0));
    count_d  = count_q + (do_push ? CW'(1) : CW'(0)) - (do_pop ? CW'(1) : CW'(0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign head_data = empty ? '0 : mem_q[rd_ptr_q];

endmodule

`default_nettype wire

// File: rtl/glb_read_dma.sv
// ============================================================
// glb_read_dma : strided GLB reader streaming words out with credit-based flow control
// Rev 1.0
// ============================================================
`default_nettype none

module glb_read_dma
  import glb_dma_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16,
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  len,
  input  logic [ADDR_WIDTH-1:0] stride,
  output logic                  busy,
  output logic                  done,
  output logic                  glb_re,
  output logic [ADDR_WIDTH-1:0] glb_r_addr,
  input  logic [DATA_WIDTH-1:0] glb_dout,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  input  logic                  m_ready
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  dma_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] stride_q, stride_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  issued_q, issued_d;
  logic [LEN_WIDTH-1:0]  captured_q, captured_d;
  logic                  pending_q, pending_d;
  logic                  done_q, done_d;

  logic [CW-1:0]         fifo_count;
  logic                  fifo_empty;
  logic [DATA_WIDTH:0]   fifo_head;
  logic                  last_issue;
  logic                  final_hs;

  // Credit check: an in-flight read always has a FIFO slot reserved.
  assign glb_re = (state_q == ST_RUN) && (issued_q < len_q) &&
                  ((CW'(pending_q) + fifo_count) < CW'(FIFO_DEPTH));

  assign last_issue = (issued_q == (len_q - LEN_WIDTH'(1)));
  assign m_valid    = !fifo_empty;
  assign m_data     = fifo_head[DATA_WIDTH-1:0];
  assign m_last     = fifo_head[DATA_WIDTH];
  assign final_hs   = m_valid && m_ready && m_last;
  assign busy       = (state_q != ST_IDLE);
  assign done       = done_q;
  assign glb_r_addr = addr_q;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    stride_d   = stride_q;
    len_d      = len_q;
    issued_d   = issued_q;
    captured_d = captured_q;
    pending_d  = glb_re;
    done_d     = 1'b0;

    // Address stays on the final issued word so IDLE shows the last address read.
    if (glb_re) begin
      issued_d = issued_q + LEN_WIDTH'(1);
      if (!last_issue) begin
        addr_d = addr_q + stride_q;
      end
    end
    if (pending_q) begin
      captured_d = captured_q + LEN_WIDTH'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (len != '0) begin
            state_d    = ST_RUN;
            addr_d     = base_addr;
            len_d      = len;
            stride_d   = stride;
            issued_d   = '0;
            captured_d = '0;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (glb_re && last_issue) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (final_hs) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      stride_q   <= '0;
      len_q      <= '0;
      issued_q   <= '0;
      captured_q <= '0;
      pending_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      stride_q   <= stride_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      captured_q <= captured_d;
      pending_q  <= pending_d;
      done_q     <= done_d;
    end
  end

  glb_dma_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (pending_q),
    .push_data ({(captured_q == (len_q - LEN_WIDTH'(1))), glb_dout}),
    .pop       (m_ready),
    .head_data (fifo_head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule

`default_nettype wire

// File: tb/tb_glb_read_dma.sv
// ============================================================
// tb_glb_read_dma : scoreboard bench for glb_read_dma
// Rev 1.0
// ============================================================
`default_nettype none

module tb_glb_read_dma;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] base_addr;
  logic [15:0] len;
  logic [31:0] stride;
  logic        busy;
  logic        done;
  logic        glb_re;
  logic [31:0] glb_r_addr;
  logic [31:0] glb_dout;
  logic        m_valid;
  logic [31:0] m_data;
  logic        m_last;
  logic        m_ready;

  int checks   = 0;
  int errors   = 0;
  int read_cnt = 0;
  int hs_cnt   = 0;
  int done_cnt = 0;
  int ready_mode = 1;

  logic [31:0] exp_addr_q[$];
  logic [32:0] exp_word_q[$];
  logic        prev_stall = 1'b0;
  logic [32:0] held_word  = '0;

  always #5 clk = ~clk;

  glb_read_dma dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .base_addr  (base_addr),
    .len        (len),
    .stride     (stride),
    .busy       (busy),
    .done       (done),
    .glb_re     (glb_re),
    .glb_r_addr (glb_r_addr),
    .glb_dout   (glb_dout),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_last     (m_last),
    .m_ready    (m_ready)
  );

  function automatic logic [31:0] glb_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  // GLB memory model: one-cycle read latency, zero when not read.
  initial glb_dout = '0;
  always @(posedge clk) glb_dout <= glb_re ? glb_word(glb_r_addr) : 32'h0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input logic [63:0] act);
    checks++;
    errors++;
    $display("FAIL %s actual=0x%0h required=none", name, act);
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (glb_re) begin
        read_cnt++;
        if (exp_addr_q.size() == 0) fail("unexpected_read", 64'(glb_r_addr));
        else chk("glb_r_addr", 64'(glb_r_addr), 64'(exp_addr_q.pop_front()));
      end
      if (prev_stall) begin
        chk("stall_valid", 64'(m_valid), 64'd1);
        chk("stall_word", 64'({m_last, m_data}), 64'(held_word));
      end
      if (m_valid && m_ready) begin
        hs_cnt++;
        if (exp_word_q.size() == 0) fail("unexpected_word", 64'({m_last, m_data}));
        else chk("stream_word", 64'({m_last, m_data}), 64'(exp_word_q.pop_front()));
      end
      prev_stall = m_valid && !m_ready;
      held_word  = {m_last, m_data};
      if (done) done_cnt++;
    end
  end

  initial begin
    m_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       m_ready = 1'b0;
        1:       m_ready = 1'b1;
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [31:0] b, input logic [15:0] n, input logic [31:0] s);
    for (int k = 0; k < int'(n); k++) begin
      exp_addr_q.push_back(b + 32'(k) * s);
      exp_word_q.push_back({(k == int'(n) - 1), glb_word(b + 32'(k) * s)});
    end
    base_addr = b;
    len       = n;
    stride    = s;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic finish_xfer(input int target, input int budget);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      tick();
      n++;
    end
    if (done_cnt < target) fail("done_timeout", 64'(done_cnt));
    tick();
    tick();
    chk("done_count", 64'(done_cnt), 64'(target));
    chk("words_left", 64'(exp_word_q.size()), 64'd0);
    chk("addrs_left", 64'(exp_addr_q.size()), 64'd0);
  endtask

  initial begin
    int r0;
    int h0;
    int n;
    rst_n     = 1'b0;
    start     = 1'b0;
    base_addr = '0;
    len       = '0;
    stride    = '0;
    #2;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_re", 64'(glb_re), 64'd0);
    chk("rst_addr", 64'(glb_r_addr), 64'd0);
    chk("rst_valid", 64'(m_valid), 64'd0);
    chk("rst_data", 64'({m_last, m_data}), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Basic transfer: back-to-back reads, first word two cycles after start
    launch(32'h100, 16'd4, 32'd4);
    chk("t1_re_c1", 64'(glb_re), 64'd1);
    chk("t1_valid_c1", 64'(m_valid), 64'd0);
    chk("t1_busy", 64'(busy), 64'd1);
    tick();
    chk("t1_re_c2", 64'(glb_re), 64'd1);
    chk("t1_valid_c2", 64'(m_valid), 64'd0);
    tick();
    chk("t1_re_c3", 64'(glb_re), 64'd1);
    chk("t1_valid_c3", 64'(m_valid), 64'd1);
    tick();
    chk("t1_re_c4", 64'(glb_re), 64'd1);
    finish_xfer(1, 50);
    chk("t1_idle_addr", 64'(glb_r_addr), 64'h10C);

    // Backpressure: only FIFO_DEPTH reads may be outstanding
    ready_mode = 0;
    tick();
    tick();
    r0 = read_cnt;
    launch(32'h200, 16'd8, 32'd4);
    repeat (10) tick();
    chk("t2_reads_stalled", 64'(read_cnt - r0), 64'd4);
    chk("t2_re_low", 64'(glb_re), 64'd0);
    ready_mode = 1;
    finish_xfer(2, 60);

    // Address wrap
    launch(32'hFFFF_FFF8, 16'd4, 32'd4);
    finish_xfer(3, 50);

    // Zero-length start
    r0        = read_cnt;
    base_addr = 32'h300;
    len       = 16'd0;
    stride    = 32'd4;
    start     = 1'b1;
    tick();
    start = 1'b0;
    chk("t4_done_pulse", 64'(done), 64'd1);
    chk("t4_busy", 64'(busy), 64'd0);
    tick();
    chk("t4_done_low", 64'(done), 64'd0);
    chk("t4_busy2", 64'(busy), 64'd0);
    repeat (3) tick();
    chk("t4_no_reads", 64'(read_cnt - r0), 64'd0);
    chk("t4_done_count", 64'(done_cnt), 64'd4);

    // Start while busy ignored; reset mid-transfer
    h0 = hs_cnt;
    launch(32'h400, 16'd16, 32'd8);
    base_addr = 32'h9000;
    len       = 16'd5;
    stride    = 32'd4;
    start     = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while ((hs_cnt - h0) < 3 && n < 50) begin
      tick();
      n++;
    end
    if ((hs_cnt - h0) < 3) fail("t5_hs_timeout", 64'(hs_cnt - h0));
    rst_n = 1'b0;
    #1;
    chk("t5_rst_busy", 64'(busy), 64'd0);
    chk("t5_rst_done", 64'(done), 64'd0);
    chk("t5_rst_re", 64'(glb_re), 64'd0);
    chk("t5_rst_addr", 64'(glb_r_addr), 64'd0);
    chk("t5_rst_valid", 64'(m_valid), 64'd0);
    chk("t5_rst_word", 64'({m_last, m_data}), 64'd0);
    #1;
    rst_n = 1'b1;
    exp_addr_q.delete();
    exp_word_q.delete();
    repeat (4) tick();
    chk("t5_no_done", 64'(done_cnt), 64'd4);
    chk("t5_valid_after", 64'(m_valid), 64'd0);
    launch(32'h40, 16'd2, 32'd4);
    finish_xfer(5, 40);

    // Random backpressure, long transfer
    ready_mode = 2;
    tick();
    launch(32'h1000, 16'd64, 32'd1);
    finish_xfer(6, 2000);
    ready_mode = 1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/glb_read_dma.md
GLB_READ_DMA -- requirements
Module: glb_read_dma

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, the GLB byte-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, the GLB read-word width.
REQ-003 SHALL have parameter LEN_WIDTH, default 16, the transfer-length counter width.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4 (power of 2, >=2), the output buffer depth in words.
REQ-005 SHALL have ports, one clock and one asynchronous active-low reset, in this order:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle descriptor launch; sampled only in IDLE.
- base_addr  in  ADDR_WIDTH  first byte address.
- len  in  LEN_WIDTH  word count.
- stride  in  ADDR_WIDTH  byte increment between words.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse after the last word handshakes.
- glb_re  out  1  GLB read enable.
- glb_r_addr  out  ADDR_WIDTH  GLB byte read address.
- glb_dout  in  DATA_WIDTH  GLB read data, valid the cycle after glb_re.
- m_valid  out  1  stream data valid.
- m_data  out  DATA_WIDTH  stream word.
- m_last  out  1  marks the final word of the transfer.
- m_ready  in  1  downstream accept.

Function
REQ-006 SHALL implement FSM IDLE -> RUN -> DRAIN -> IDLE.
- IDLE->RUN: start with len!=0.
- RUN->DRAIN: final read issued.
- DRAIN->IDLE: final word handshakes (m_valid&m_ready&m_last).
REQ-007 SHALL, on start with len==0, stay in IDLE, issue no reads, and pulse done the next cycle.
REQ-008 SHALL ignore start whenever busy=1.
REQ-009 SHALL latch base_addr, len and stride on start acceptance; later changes to these inputs SHALL NOT affect the running transfer.
REQ-010 SHALL form the address of word k as base_addr + k*stride, modulo 2^ADDR_WIDTH, wrapping silently.
- The address is an incremented register; no multiplier.
REQ-011 SHALL drive glb_re combinationally from registered state: RUN && issued<len && (outstanding + fifo_count) < FIFO_DEPTH.
REQ-012 SHALL treat GLB read latency as exactly 1 cycle.
- glb_dout is written into the FIFO in the cycle after glb_re=1.
- glb_dout is ignored in all other cycles, because the GLB drives 0 when not read.
REQ-013 SHALL never drop or duplicate a word.
- The credit check in REQ-011 guarantees FIFO space for every in-flight read.
REQ-014 SHALL assert m_valid whenever the FIFO is non-empty.
- m_data/m_last SHALL hold stable while m_valid=1 and m_ready=0.
REQ-015 SHALL tag word len-1 with m_last=1 and all others with m_last=0.
REQ-016 SHALL sustain 1 word/cycle once the pipeline has filled, with m_ready held high.
- First m_valid arrives 2 cycles after start: issue cycle, then capture cycle.
REQ-017 SHALL allow a FIFO push and pop in the same cycle, including when the FIFO is full (pop frees the slot) and when it is empty (push only).
REQ-018 SHALL pulse done for one cycle, the cycle after the final handshake.
- busy SHALL fall in that same cycle.
- start SHALL be accepted in that cycle or any later IDLE cycle.
REQ-019 SHALL, in IDLE, hold glb_re=0 and hold glb_r_addr at its last value.

Reset
REQ-020 SHALL, while rst_n=0, asynchronously force all of the following:
- state=IDLE; busy=0; done=0.
- glb_re=0; glb_r_addr=0.
- m_valid=0; m_data=0; m_last=0.
- FIFO empty; all counters 0.
REQ-021 SHALL abandon an in-flight transfer on reset.
- No done pulse is issued.
- A pending GLB read result arriving after rst_n rises SHALL be discarded.

Structure
REQ-022 SHALL place the FSM state enum and the default FIFO_DEPTH constant in shared package glb_dma_pkg.
REQ-023 SHALL implement buffering in one sub-module, glb_dma_fifo: a synchronous FIFO with count output.
- All control logic SHALL stay in glb_read_dma.

Verification
REQ-024 Bench: base=0x100, len=4, stride=4, m_ready=1.
- glb_r_addr SHALL be 0x100,0x104,0x108,0x10C on consecutive cycles.
- 4 words SHALL emerge in order, with m_last on the 4th.
- done SHALL pulse once.
REQ-025 Bench: len=8, m_ready=0 for 10 cycles, then 1.
- Exactly FIFO_DEPTH=4 reads SHALL issue, then glb_re=0.
- After release, all 8 words SHALL arrive without loss.
REQ-026 Bench: base=0xFFFFFFF8, stride=4, len=4.
- Addresses SHALL be 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4.
REQ-027 Bench: start with len=0.
- glb_re SHALL never assert.
- done SHALL pulse the next cycle; busy SHALL stay 0.
REQ-028 Bench: start again while busy, then rst_n low mid-transfer after 3 words.
- The second start SHALL be ignored.
- All outputs SHALL return to reset values immediately; no done pulse.
- A fresh len=2 transfer after reset SHALL complete correctly.
REQ-029 Bench: random m_ready (50%) over len=64, stride=1.
- The output sequence SHALL match a GLB scoreboard exactly.
- m_data SHALL stay stable under backpressure.
